// File: rtl/fp_pkg.sv
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared constants and types for the float-to-integer converter.
//                It provides:
//                  - IEEE-754 single-precision bias and all-ones exponent.
//                  - Signed 32-bit integer limits.
//                  - The converter state encoding.
//                  - The unpacked-float record.
//  Config      : none (FP2INT_ROUND_NEAREST_EN is consumed by fp2int_round_sat)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

    // Exponent bias for an 8-bit exponent: 2^(8-1)-1
    localparam int BIAS    = 127;
    // All-ones exponent marks Inf/NaN
    localparam int EXP_MAX = 255;

    // Two's-complement limits of the 32-bit integer result
    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    // Converter control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ROUND = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Field view of a single-precision operand (MSB first)
    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } fp_unpacked_t;

endpackage : fp_pkg

`default_nettype wire

// File: rtl/fp2int_round_sat.sv
// ============================================================================
//  Module      : fp2int_round_sat
//  Description : Combinational back end of the float-to-integer converter.
//                It takes the de-normalized magnitude with its guard/sticky
//                bits and produces the final two's-complement result, in order:
//                  - optional round-to-nearest-even,
//                  - negation,
//                  - saturation,
//                  - overflow/invalid/inexact flags.
//  Ports       : i_sign       operand sign
//                i_mag        unsigned integer magnitude before rounding
//                i_guard      first discarded fraction bit
//                i_sticky     OR of all remaining discarded fraction bits
//                i_force_ovf  operand is Inf or |value| >= 2^31
//                i_force_inv  operand is NaN
//                o_result     two's-complement integer result
//                o_overflow   result saturated
//                o_invalid    NaN operand
//                o_inexact    nonzero fraction discarded
//  Config      : FP2INT_ROUND_NEAREST_EN - when defined, round to nearest
//                even; otherwise truncate toward zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp2int_round_sat
    import fp_pkg::*;
#(
    parameter int INT_WIDTH = 32
) (
    input  logic                 i_sign,
    input  logic [INT_WIDTH-1:0] i_mag,
    input  logic                 i_guard,
    input  logic                 i_sticky,
    input  logic                 i_force_ovf,
    input  logic                 i_force_inv,
    output logic [INT_WIDTH-1:0] o_result,
    output logic                 o_overflow,
    output logic                 o_invalid,
    output logic                 o_inexact
);

    localparam int c_ext_w = INT_WIDTH + 1;

    localparam logic [INT_WIDTH-1:0] c_int_max = INT_WIDTH'(INT_MAX);
    localparam logic [INT_WIDTH-1:0] c_int_min = INT_WIDTH'(INT_MIN);

    // Largest representable magnitudes: 2^31-1 for positive, 2^31 for negative
    localparam logic [INT_WIDTH:0] c_pos_lim = {1'b0, c_int_max};
    localparam logic [INT_WIDTH:0] c_neg_lim = {1'b0, c_int_min};

    logic                 w_round_up;
    logic [INT_WIDTH:0]   w_mag_rnd;
    logic [INT_WIDTH-1:0] w_mag_lo;
    logic [INT_WIDTH-1:0] w_neg;
    logic                 w_too_big;

`ifdef FP2INT_ROUND_NEAREST_EN
    // Round half to even: bump when above half, or exactly half with odd LSB
    assign w_round_up = i_guard & (i_sticky | i_mag[0]);
`else
    // Truncate toward zero; guard/sticky only report inexactness
    assign w_round_up = 1'b0;
`endif

    // One extra bit so a carry out of the rounding increment is visible
    assign w_mag_rnd = {1'b0, i_mag} + c_ext_w'(w_round_up);
    assign w_mag_lo  = w_mag_rnd[INT_WIDTH-1:0];
    assign w_neg     = '0 - w_mag_lo;

    // Negative side may reach 2^31 exactly (INT_MIN), positive side may not
    assign w_too_big = i_sign ? (w_mag_rnd > c_neg_lim) : (w_mag_rnd > c_pos_lim);

    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        o_invalid  = 1'b0;
        o_inexact  = 1'b0;
        if (i_force_inv) begin
            o_result  = c_int_min;
            o_invalid = 1'b1;
        end else if (i_force_ovf || w_too_big) begin
            o_result   = i_sign ? c_int_min : c_int_max;
            o_overflow = 1'b1;
        end else begin
            o_result  = i_sign ? w_neg : w_mag_lo;
            o_inexact = i_guard | i_sticky;
        end
    end

endmodule : fp2int_round_sat

`default_nettype wire

// File: rtl/float_to_int_converter.sv
// ============================================================================
//  Module      : float_to_int_converter
//  Description : Multi-cycle IEEE-754 single-precision to signed 32-bit
//                integer converter with valid/ready handshakes on both sides.
//                Flow of a conversion:
//                  - The operand is decoded at accept time.
//                  - The significand is de-normalized one bit per cycle.
//                  - The result is rounded/saturated by fp2int_round_sat.
//                  - The result is held until the consumer takes it.
//                Latency, counting the accept cycle as cycle 1, is N+2
//                cycles, where N is the number of 1-bit shifts.
//  Ports       : clk_in        clock, rising edge
//                rst_n_in      asynchronous active-low reset
//                valid_in      upstream presents floating_in
//                ready_out     converter can accept (IDLE only)
//                floating_in   single-precision operand
//                integer_out   two's-complement result
//                valid_out     result and flags valid
//                ready_in      downstream accepts the result
//                overflow_out  result saturated
//                invalid_out   NaN operand
//                inexact_out   nonzero fraction discarded
//  Config      : FP2INT_ROUND_NEAREST_EN - round to nearest even instead of
//                truncating (handled in fp2int_round_sat).
//  Notes       : Parameters are expected at their single-precision / 32-bit
//                defaults; the operand layout follows fp_pkg::fp_unpacked_t.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module float_to_int_converter
    import fp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MENT_WIDTH = 23,
    parameter int EXPO_WIDTH = 8,
    parameter int INT_WIDTH  = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [DATA_WIDTH-1:0] floating_in,
    output logic [INT_WIDTH-1:0]  integer_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  overflow_out,
    output logic                  invalid_out,
    output logic                  inexact_out
);

    // Shift counter must hold up to MENT_WIDTH (value 1.0 shifts right 23 times)
    localparam int c_cnt_w = $clog2(MENT_WIDTH + 1);

    // Biased exponent thresholds that select the conversion path
    localparam logic [EXPO_WIDTH-1:0] c_exp_max  = EXPO_WIDTH'(EXP_MAX);
    localparam logic [EXPO_WIDTH-1:0] c_exp_sat  = EXPO_WIDTH'(BIAS + INT_WIDTH - 1);
    localparam logic [EXPO_WIDTH-1:0] c_exp_left = EXPO_WIDTH'(BIAS + MENT_WIDTH);
    localparam logic [EXPO_WIDTH-1:0] c_exp_one  = EXPO_WIDTH'(BIAS);
    localparam logic [EXPO_WIDTH-1:0] c_exp_half = EXPO_WIDTH'(BIAS - 1);

    localparam logic [INT_WIDTH-1:0]  c_min_mag  = INT_WIDTH'(INT_MIN);
    localparam logic [c_cnt_w-1:0]    c_cnt_one  = c_cnt_w'(1);

    // ------------------------------------------------------------------
    // Operand decode (evaluated every cycle, captured on accept)
    // ------------------------------------------------------------------
    fp_unpacked_t          w_in;
    logic [MENT_WIDTH:0]   w_sig;
    logic [INT_WIDTH-1:0]  w_mag_init;
    logic                  w_guard_init;
    logic                  w_sticky_init;
    logic                  w_left;
    logic [c_cnt_w-1:0]    w_cnt_init;
    logic                  w_force_ovf;
    logic                  w_force_inv;
    logic                  w_accept;

    assign w_in     = fp_unpacked_t'(floating_in);
    assign w_sig    = {1'b1, w_in.mantissa};
    assign w_accept = valid_in && ready_out;

    always_comb begin
        w_mag_init    = '0;
        w_guard_init  = 1'b0;
        w_sticky_init = 1'b0;
        w_left        = 1'b0;
        w_cnt_init    = '0;
        w_force_ovf   = 1'b0;
        w_force_inv   = 1'b0;
        if (w_in.exponent == c_exp_max) begin
            // NaN is invalid; Inf saturates
            if (w_in.mantissa != '0) begin
                w_force_inv = 1'b1;
            end else begin
                w_force_ovf = 1'b1;
            end
        end else if (w_in.exponent >= c_exp_sat) begin
            // |value| >= 2^31: only exactly -2^31 is representable
            if (w_in.sign && (w_in.exponent == c_exp_sat) && (w_in.mantissa == '0)) begin
                w_mag_init = c_min_mag;
            end else begin
                w_force_ovf = 1'b1;
            end
        end else if (w_in.exponent >= c_exp_left) begin
            // e in 23..30: integer needs left shifting, no fraction bits
            w_left     = 1'b1;
            w_mag_init = INT_WIDTH'(w_sig);
            w_cnt_init = c_cnt_w'(w_in.exponent - c_exp_left);
        end else if (w_in.exponent >= c_exp_one) begin
            // e in 0..22: shift fraction bits out into guard/sticky
            w_mag_init = INT_WIDTH'(w_sig);
            w_cnt_init = c_cnt_w'(c_exp_left - w_in.exponent);
        end else if (w_in.exponent == c_exp_half) begin
            // e = -1: the hidden one is the guard bit
            w_guard_init  = 1'b1;
            w_sticky_init = (w_in.mantissa != '0);
        end else if (w_in.exponent == '0) begin
            // Zero or denormal: magnitude well below one half
            w_sticky_init = (w_in.mantissa != '0);
        end else begin
            // e < -1: nonzero but below one half
            w_sticky_init = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Working registers
    // ------------------------------------------------------------------
    state_t               r_state;
    logic                 r_sign;
    logic [INT_WIDTH-1:0] r_mag;
    logic                 r_guard;
    logic                 r_sticky;
    logic                 r_left;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_force_ovf;
    logic                 r_force_inv;

    logic                 r_ready;
    logic                 r_valid;
    logic [INT_WIDTH-1:0] r_integer;
    logic                 r_overflow;
    logic                 r_invalid;
    logic                 r_inexact;

    // ------------------------------------------------------------------
    // Round / negate / saturate
    // ------------------------------------------------------------------
    logic [INT_WIDTH-1:0] w_rs_result;
    logic                 w_rs_overflow;
    logic                 w_rs_invalid;
    logic                 w_rs_inexact;

    fp2int_round_sat #(
        .INT_WIDTH (INT_WIDTH)
    ) u_round_sat (
        .i_sign      (r_sign),
        .i_mag       (r_mag),
        .i_guard     (r_guard),
        .i_sticky    (r_sticky),
        .i_force_ovf (r_force_ovf),
        .i_force_inv (r_force_inv),
        .o_result    (w_rs_result),
        .o_overflow  (w_rs_overflow),
        .o_invalid   (w_rs_invalid),
        .o_inexact   (w_rs_inexact)
    );

    // ------------------------------------------------------------------
    // Control FSM with shifter and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= IDLE;
            r_sign      <= 1'b0;
            r_mag       <= '0;
            r_guard     <= 1'b0;
            r_sticky    <= 1'b0;
            r_left      <= 1'b0;
            r_cnt       <= '0;
            r_force_ovf <= 1'b0;
            r_force_inv <= 1'b0;
            r_ready     <= 1'b1;
            r_valid     <= 1'b0;
            r_integer   <= '0;
            r_overflow  <= 1'b0;
            r_invalid   <= 1'b0;
            r_inexact   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sign      <= w_in.sign;
                        r_mag       <= w_mag_init;
                        r_guard     <= w_guard_init;
                        r_sticky    <= w_sticky_init;
                        r_left      <= w_left;
                        r_cnt       <= w_cnt_init;
                        r_force_ovf <= w_force_ovf;
                        r_force_inv <= w_force_inv;
                        r_ready     <= 1'b0;
                        r_state     <= (w_cnt_init == '0) ? ROUND : SHIFT;
                    end
                end

                SHIFT: begin
                    if (r_left) begin
                        r_mag <= r_mag << 1;
                    end else begin
                        // The bit leaving the integer becomes guard; the old
                        // guard is folded into sticky.
                        r_mag    <= r_mag >> 1;
                        r_guard  <= r_mag[0];
                        r_sticky <= r_sticky | r_guard;
                    end
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == c_cnt_one) begin
                        r_state <= ROUND;
                    end
                end

                ROUND: begin
                    r_integer  <= w_rs_result;
                    r_overflow <= w_rs_overflow;
                    r_invalid  <= w_rs_invalid;
                    r_inexact  <= w_rs_inexact;
                    r_valid    <= 1'b1;
                    r_state    <= HOLD;
                end

                HOLD: begin
                    if (ready_in) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready_out    = r_ready;
    assign valid_out    = r_valid;
    assign integer_out  = r_integer;
    assign overflow_out = r_overflow;
    assign invalid_out  = r_invalid;
    assign inexact_out  = r_inexact;

endmodule : float_to_int_converter

`default_nettype wire

// File: tb/tb_float_to_int_converter.sv
// ============================================================================
//  Module      : tb_float_to_int_converter
//  Description : Scoreboard bench for float_to_int_converter. The driver
//                pushes the hand-computed expected result when an operand is
//                accepted; the monitor pops and compares on each rising
//                valid_out. Latency counts the accept cycle as cycle 1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_float_to_int_converter;

`ifdef FP2INT_ROUND_NEAREST_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [31:0] floating_in = '0;
    logic [31:0] integer_out;
    logic        valid_out;
    logic        ready_in = 1'b1;
    logic        overflow_out;
    logic        invalid_out;
    logic        inexact_out;

    float_to_int_converter dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .floating_in  (floating_in),
        .integer_out  (integer_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .overflow_out (overflow_out),
        .invalid_out  (invalid_out),
        .inexact_out  (inexact_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] f;
        logic [31:0] data;
        logic        ovf;
        logic        inv;
        logic        inx;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic vprev  = 1'b0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: compare every new result against the oldest expectation
    always @(posedge clk_in) begin
        #1;
        if (valid_out && !vprev) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", integer_out, 32'hxxxx_xxxx);
            end else begin
                me = sb.pop_front();
                chk($sformatf("int[%h]", me.f), integer_out, me.data);
                chk($sformatf("ovf[%h]", me.f), 32'(overflow_out), 32'(me.ovf));
                chk($sformatf("inv[%h]", me.f), 32'(invalid_out), 32'(me.inv));
                chk($sformatf("inx[%h]", me.f), 32'(inexact_out), 32'(me.inx));
                chk($sformatf("lat[%h]", me.f), 32'(cyc - me.acc + 1), 32'(me.lat));
            end
        end
        vprev = valid_out;
    end

    task automatic send(input logic [31:0] f, input logic [31:0] d, input logic ovf,
                        input logic inv, input logic inx, input int lat, input bit push = 1'b1);
        exp_t e;
        int   t = 0;
        @(negedge clk_in);
        while (!ready_out && t < 200) begin
            @(negedge clk_in);
            t++;
        end
        if (!ready_out) begin
            chk("accept_timeout", 32'(ready_out), 32'd1);
            return;
        end
        valid_in    = 1'b1;
        floating_in = f;
        @(posedge clk_in);
        #1;
        e.f = f; e.data = d; e.ovf = ovf; e.inv = inv; e.inx = inx; e.lat = lat; e.acc = cyc;
        if (push) sb.push_back(e);
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || !ready_out) && t < 500) begin
            @(negedge clk_in);
            t++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int t;
        // Reset held across a few edges
        repeat (3) @(negedge clk_in);
        chk("rst_int",   integer_out,         32'd0);
        chk("rst_valid", 32'(valid_out),      32'd0);
        chk("rst_ready", 32'(ready_out),      32'd1);
        chk("rst_flags", {29'd0, overflow_out, invalid_out, inexact_out}, 32'd0);
        rst_n_in = 1'b1;

        // data, ovf, inv, inx, latency (N+2)
        send(32'h4060_0000, RNE ? 32'd4 : 32'd3,                       0, 0, 1, 24); // 3.5
        send(32'h4020_0000, 32'd2,                                     0, 0, 1, 24); // 2.5
        send(32'hC060_0000, RNE ? 32'hFFFF_FFFC : 32'hFFFF_FFFD,       0, 0, 1, 24); // -3.5
        send(32'hBF80_0000, 32'hFFFF_FFFF,                             0, 0, 0, 25); // -1.0
        send(32'h4EFF_FFFF, 32'h7FFF_FF80,                             0, 0, 0, 9);  // e=30
        send(32'h4B00_0000, 32'h0080_0000,                             0, 0, 0, 2);  // 2^23, N=0
        send(32'h4F00_0000, 32'h7FFF_FFFF,                             1, 0, 0, 2);  // 2^31
        send(32'hCF00_0000, 32'h8000_0000,                             0, 0, 0, 2);  // -2^31 exact
        send(32'hCF00_0001, 32'h8000_0000,                             1, 0, 0, 2);  // below -2^31
        send(32'hFF80_0000, 32'h8000_0000,                             1, 0, 0, 2);  // -Inf
        send(32'h7F80_0000, 32'h7FFF_FFFF,                             1, 0, 0, 2);  // +Inf
        send(32'h7FC0_0000, 32'h8000_0000,                             0, 1, 0, 2);  // NaN
        send(32'h0000_0001, 32'd0,                                     0, 0, 1, 2);  // denormal
        send(32'h8000_0000, 32'd0,                                     0, 0, 0, 2);  // -0.0
        send(32'h3F00_0000, 32'd0,                                     0, 0, 1, 2);  // 0.5 tie
        send(32'h3F40_0000, RNE ? 32'd1 : 32'd0,                       0, 0, 1, 2);  // 0.75
        send(32'h3E80_0000, 32'd0,                                     0, 0, 1, 2);  // 0.25
        drain();

        // Backpressure: result held, new operand ignored while busy
        ready_in = 1'b0;
        send(32'h4120_0000, 32'd10, 0, 0, 0, 22);
        t = 0;
        while (!valid_out && t < 100) begin
            @(negedge clk_in);
            t++;
        end
        chk("bp_valid_timeout", 32'(valid_out), 32'd1);
        valid_in    = 1'b1;
        floating_in = 32'h4000_0000;
        repeat (5) begin
            @(negedge clk_in);
            chk("bp_valid", 32'(valid_out), 32'd1);
            chk("bp_int",   integer_out,    32'd10);
            chk("bp_ready", 32'(ready_out), 32'd0);
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        send(32'h4000_0000, 32'd2, 0, 0, 0, 24);
        drain();

        // Reset in the middle of a long right shift aborts the conversion
        send(32'h3F80_0000, 32'd1, 0, 0, 0, 25, 1'b0);
        repeat (5) @(negedge clk_in);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("abort_int",   integer_out,    32'd0);
        chk("abort_valid", 32'(valid_out), 32'd0);
        chk("abort_ready", 32'(ready_out), 32'd1);
        chk("abort_flags", {29'd0, overflow_out, invalid_out, inexact_out}, 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        send(32'h4120_0000, 32'd10, 0, 0, 0, 22);
        drain();
        repeat (3) @(negedge clk_in);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_float_to_int_converter

`default_nettype wire
